// File: rtl/jtvigil_scr2.sv
// Vigilante rear scroll layer: fetches 8-pixel 4bpp words from graphics ROM,
// applies horizontal scroll and shifts out one pixel per pxl_cen.
//   state    | meaning
//   ST_IDLE  | outside the active window, no ROM request
//   ST_FETCH | request pending for rom_addr, settle guards the first clk
//   ST_HOLD  | word for the next tile captured in buf_q
module jtvigil_scr2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        pxl_cen,
  input  logic [8:0]  h,
  input  logic [8:0]  v,
  input  logic [10:0] scrpos,
  output logic [17:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic        rom_cs,
  input  logic        rom_ok,
  output logic [3:0]  pxl
);
  typedef enum logic [1:0] { ST_IDLE, ST_FETCH, ST_HOLD } st_t;

  st_t         st_q, st_d;
  logic [10:0] spos_q, spos_d;
  logic [17:0] addr_q, addr_d;
  logic        cs_q, cs_d;
  logic        settle_q, settle_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] shift_q, shift_d;
  logic [3:0]  pxl_q, pxl_d;

  logic [10:0] hx, spos_use, hs;
  logic [7:0]  col_nx;
  logic [17:0] addr_nx;
  logic        start, leave, active, visible, accept, tile;
  logic [31:0] fresh;
  logic        unused_v;

  assign unused_v = v[8];

  // h runs 0..383, so h[8] alone marks the blanking part that maps to hx<0
  assign hx       = h[8] ? ({2'b00, h} - 11'd384) : {2'b00, h};
  assign start    = pxl_cen && (h == 9'd360);
  assign leave    = pxl_cen && (h == 9'd256);
  assign active   = !h[8] || (h >= 9'd360);
  assign visible  = !h[8];
  assign spos_use = start ? scrpos : spos_q;
  assign hs       = hx + spos_use;
  assign col_nx   = hs[10:3] + 8'd1;
  assign addr_nx  = {1'b0, col_nx, v[7:0], 1'b0};
  assign accept   = (st_q == ST_FETCH) && !settle_q && rom_ok;
  assign tile     = (hs[2:0] == 3'd0);

  // Data arriving on the boundary clk counts as a hit; still fetching is a miss
  assign fresh = accept ? rom_data : ((st_q == ST_HOLD) ? buf_q : 32'd0);

  always_comb begin
    st_d     = st_q;
    spos_d   = spos_q;
    addr_d   = addr_q;
    cs_d     = cs_q;
    settle_d = 1'b0;
    buf_d    = buf_q;
    shift_d  = shift_q;
    pxl_d    = pxl_q;
    if (accept) begin
      buf_d = rom_data;
      cs_d  = 1'b0;
      st_d  = ST_HOLD;
    end
    if (pxl_cen) begin
      pxl_d = 4'd0;
      if (start) begin
        spos_d   = scrpos;
        addr_d   = addr_nx;
        cs_d     = 1'b1;
        settle_d = 1'b1;
        st_d     = ST_FETCH;
      end else if (leave) begin
        st_d = ST_IDLE;
        cs_d = 1'b0;
      end else if (active && (st_q != ST_IDLE)) begin
        if (tile) begin
          shift_d  = fresh << 4;
          if (visible) pxl_d = fresh[31:28];
          addr_d   = addr_nx;
          cs_d     = 1'b1;
          settle_d = 1'b1;
          st_d     = ST_FETCH;
        end else begin
          shift_d = shift_q << 4;
          if (visible) pxl_d = shift_q[31:28];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= ST_IDLE;
      spos_q   <= 11'd0;
      addr_q   <= 18'd0;
      cs_q     <= 1'b0;
      settle_q <= 1'b0;
      buf_q    <= 32'd0;
      shift_q  <= 32'd0;
      pxl_q    <= 4'd0;
    end else begin
      st_q     <= st_d;
      spos_q   <= spos_d;
      addr_q   <= addr_d;
      cs_q     <= cs_d;
      settle_q <= settle_d;
      buf_q    <= buf_d;
      shift_q  <= shift_d;
      pxl_q    <= pxl_d;
    end
  end

  assign rom_addr = addr_q;
  assign rom_cs   = cs_q;
  assign pxl      = pxl_q;
endmodule
